despachante_aprovados: RTL and testbench

DESPACHANTE_APROVADOS -- requirements
Module: despachante_aprovados

---
 rtl/despachante_aprovados.sv | 181 ++++++++++++++++++
 tb/tb_despachante_aprovados.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/despachante_aprovados.sv
// Dispatcher for approved active-node slots: writes predecessors,
// offers nodes downstream in slot order and flags the target node.
module despachante_aprovados #(
  parameter int NUM_NA          = 4,
  parameter int ADDR_WIDTH      = 5,
  parameter int DISTANCIA_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              aa_pronto_in,
  input  logic                              aa_tem_aprovado_in,
  input  logic [NUM_NA-1:0]                 aa_aprovado_in,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_endereco_in,
  input  logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_in,
  input  logic [ADDR_WIDTH*NUM_NA-1:0]      aa_anterior_data_in,
  input  logic [ADDR_WIDTH-1:0]             destino_in,
  input  logic                              limpar_in,
  input  logic                              dp_ready_in,
  output logic                              dp_valid_out,
  output logic [ADDR_WIDTH-1:0]             dp_endereco_out,
  output logic [DISTANCIA_WIDTH-1:0]        dp_distancia_out,
  output logic                              ant_wr_en_out,
  output logic [ADDR_WIDTH-1:0]             ant_wr_addr_out,
  output logic [ADDR_WIDTH-1:0]             ant_wr_data_out,
  output logic                              remover_aprovados_out,
  output logic                              dp_destino_encontrado_out,
  output logic                              dp_ocupado_out
);

  localparam int IW = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DISTANCIA_WIDTH;

  typedef enum logic [2:0] {
    OCIOSO,
    SELECIONA,
    ESCREVE,
    ENVIA,
    REMOVE,
    ESPERA
  } estado_t;

  estado_t estado, estado_n;

  logic [NUM_NA-1:0]    mask, mask_n;
  logic [IW-1:0]        idx, idx_n;
  logic [AW*NUM_NA-1:0] end_q, end_n;
  logic [DW*NUM_NA-1:0] dist_q, dist_n;
  logic [AW*NUM_NA-1:0] ant_q, ant_n;

  logic          valid_n, wr_en_n, rem_n, found_n, ocup_n;
  logic [AW-1:0] dp_end_n, wr_addr_n, wr_data_n;
  logic [DW-1:0] dp_dist_n;

  function automatic logic [IW-1:0] menor_bit(
    input logic [NUM_NA-1:0] m
  );
    menor_bit = '0;
    for (int i = NUM_NA - 1; i >= 0; i--)
      if (m[i]) menor_bit = IW'(i);
  endfunction

  always_comb begin
    estado_n  = estado;
    mask_n    = mask;
    idx_n     = idx;
    end_n     = end_q;
    dist_n    = dist_q;
    ant_n     = ant_q;
    valid_n   = dp_valid_out;
    dp_end_n  = dp_endereco_out;
    dp_dist_n = dp_distancia_out;
    wr_en_n   = 1'b0;
    wr_addr_n = ant_wr_addr_out;
    wr_data_n = ant_wr_data_out;
    rem_n     = 1'b0;
    found_n   = dp_destino_encontrado_out;

    unique case (estado)
      OCIOSO: begin
        if (aa_pronto_in && aa_tem_aprovado_in &&
            !dp_destino_encontrado_out) begin
          mask_n   = aa_aprovado_in;
          end_n    = aa_endereco_in;
          dist_n   = aa_distancia_in;
          ant_n    = aa_anterior_data_in;
          estado_n = SELECIONA;
        end
      end
      SELECIONA: begin
        if (mask == '0) begin
          rem_n    = 1'b1;
          estado_n = REMOVE;
        end else begin
          idx_n     = menor_bit(mask);
          wr_en_n   = 1'b1;
          wr_addr_n = end_q[AW*idx_n +: AW];
          wr_data_n = ant_q[AW*idx_n +: AW];
          estado_n  = ESCREVE;
        end
      end
      ESCREVE: begin
        // Target reached: stop here, the node is never expanded
        if (ant_wr_addr_out == destino_in) begin
          found_n  = 1'b1;
          mask_n   = '0;
          rem_n    = 1'b1;
          estado_n = REMOVE;
        end else begin
          valid_n   = 1'b1;
          dp_end_n  = end_q[AW*idx +: AW];
          dp_dist_n = dist_q[DW*idx +: DW];
          estado_n  = ENVIA;
        end
      end
      ENVIA: begin
        if (dp_ready_in) begin
          valid_n     = 1'b0;
          mask_n[idx] = 1'b0;
          estado_n    = SELECIONA;
        end
      end
      REMOVE: begin
        estado_n = ESPERA;
      end
      ESPERA: begin
        // Wait for the evaluator to drop its stale approvals
        if (!aa_tem_aprovado_in) estado_n = OCIOSO;
      end
      default: estado_n = OCIOSO;
    endcase

    if (limpar_in) begin
      estado_n = OCIOSO;
      mask_n   = '0;
      found_n  = 1'b0;
      valid_n  = 1'b0;
      wr_en_n  = 1'b0;
      rem_n    = 1'b0;
    end

    ocup_n = (estado_n != OCIOSO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado                    <= OCIOSO;
      mask                      <= '0;
      idx                       <= '0;
      end_q                     <= '0;
      dist_q                    <= '0;
      ant_q                     <= '0;
      dp_valid_out              <= 1'b0;
      dp_endereco_out           <= '0;
      dp_distancia_out          <= '0;
      ant_wr_en_out             <= 1'b0;
      ant_wr_addr_out           <= '0;
      ant_wr_data_out           <= '0;
      remover_aprovados_out     <= 1'b0;
      dp_destino_encontrado_out <= 1'b0;
      dp_ocupado_out            <= 1'b0;
    end else begin
      estado                    <= estado_n;
      mask                      <= mask_n;
      idx                       <= idx_n;
      end_q                     <= end_n;
      dist_q                    <= dist_n;
      ant_q                     <= ant_n;
      dp_valid_out              <= valid_n;
      dp_endereco_out           <= dp_end_n;
      dp_distancia_out          <= dp_dist_n;
      ant_wr_en_out             <= wr_en_n;
      ant_wr_addr_out           <= wr_addr_n;
      ant_wr_data_out           <= wr_data_n;
      remover_aprovados_out     <= rem_n;
      dp_destino_encontrado_out <= found_n;
      dp_ocupado_out            <= ocup_n;
    end
  end

endmodule

// File: tb/tb_despachante_aprovados.sv
// Randomized bench for despachante_aprovados against a
// slot-order reference model of writes, offers and target detection.
module tb_despachante_aprovados;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aa_pronto_in;
  logic        aa_tem_aprovado_in;
  logic [3:0]  aa_aprovado_in;
  logic [19:0] aa_endereco_in;
  logic [19:0] aa_distancia_in;
  logic [19:0] aa_anterior_data_in;
  logic [4:0]  destino_in;
  logic        limpar_in;
  logic        dp_ready_in;
  logic        dp_valid_out;
  logic [4:0]  dp_endereco_out;
  logic [4:0]  dp_distancia_out;
  logic        ant_wr_en_out;
  logic [4:0]  ant_wr_addr_out;
  logic [4:0]  ant_wr_data_out;
  logic        remover_aprovados_out;
  logic        dp_destino_encontrado_out;
  logic        dp_ocupado_out;

  despachante_aprovados #(
    .NUM_NA(4), .ADDR_WIDTH(5), .DISTANCIA_WIDTH(5)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .aa_pronto_in             (aa_pronto_in),
    .aa_tem_aprovado_in       (aa_tem_aprovado_in),
    .aa_aprovado_in           (aa_aprovado_in),
    .aa_endereco_in           (aa_endereco_in),
    .aa_distancia_in          (aa_distancia_in),
    .aa_anterior_data_in      (aa_anterior_data_in),
    .destino_in               (destino_in),
    .limpar_in                (limpar_in),
    .dp_ready_in              (dp_ready_in),
    .dp_valid_out             (dp_valid_out),
    .dp_endereco_out          (dp_endereco_out),
    .dp_distancia_out         (dp_distancia_out),
    .ant_wr_en_out            (ant_wr_en_out),
    .ant_wr_addr_out          (ant_wr_addr_out),
    .ant_wr_data_out          (ant_wr_data_out),
    .remover_aprovados_out    (remover_aprovados_out),
    .dp_destino_encontrado_out(dp_destino_encontrado_out),
    .dp_ocupado_out           (dp_ocupado_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rem_cnt = 0;
  int c0      = 0;
  bit flag_m  = 0;
  bit prev_valid = 0;

  logic [9:0] wr_q[$];
  logic [9:0] dp_q[$];
  int         wr_cyc_q[$];
  int         vcyc_q[$];

  task automatic verifica(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ant_wr_en_out) begin
        wr_q.push_back({ant_wr_addr_out, ant_wr_data_out});
        wr_cyc_q.push_back(cyc);
      end
      if (dp_valid_out && !prev_valid) vcyc_q.push_back(cyc);
      if (dp_valid_out && dp_ready_in)
        dp_q.push_back({dp_endereco_out, dp_distancia_out});
      if (remover_aprovados_out) rem_cnt++;
      prev_valid = dp_valid_out;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high; mode 1: random ready.
  // hold: ready low for this many cycles at first offer.
  // esp: cycles aa_tem_aprovado_in stays high after remover.
  task automatic run_txn(input logic [3:0]  ap,
                         input logic [19:0] ad,
                         input logic [19:0] di,
                         input logic [19:0] an,
                         input logic [4:0]  de,
                         input int mode,
                         input int hold,
                         input int esp);
    logic [9:0] ew[$];
    logic [9:0] ed[$];
    bit cap;
    int rem0;
    int n;
    int lowc;
    cap = !flag_m && (ap != 0);
    if (cap) begin
      for (int i = 0; i < 4; i++) begin
        if (ap[i]) begin
          ew.push_back({ad[5*i +: 5], an[5*i +: 5]});
          if (ad[5*i +: 5] == de) begin
            flag_m = 1;
            break;
          end
          ed.push_back({ad[5*i +: 5], di[5*i +: 5]});
        end
      end
    end
    wr_q.delete();
    dp_q.delete();
    wr_cyc_q.delete();
    vcyc_q.delete();
    rem0 = rem_cnt;
    destino_in          = de;
    aa_aprovado_in      = ap;
    aa_endereco_in      = ad;
    aa_distancia_in     = di;
    aa_anterior_data_in = an;
    aa_pronto_in        = 1'b1;
    aa_tem_aprovado_in  = (ap != 0);
    dp_ready_in         = (mode == 0) && (hold == 0);
    c0 = cyc;
    tick();
    aa_pronto_in        = 1'b0;
    aa_aprovado_in      = 4'($urandom);
    aa_endereco_in      = 20'($urandom);
    aa_distancia_in     = 20'($urandom);
    aa_anterior_data_in = 20'($urandom);
    n = 0;
    lowc = 0;
    while (rem_cnt == rem0 && n < (cap ? 200 : 8)) begin
      if (dp_valid_out && lowc < hold) begin
        dp_ready_in = 1'b0;
        lowc++;
        verifica("hold_addr", dp_endereco_out, ed[0][9:5]);
      end else if (lowc > 0 && lowc <= hold) begin
        verifica("hold_valid", dp_valid_out, 1);
        dp_ready_in = 1'b1;
        lowc++;
      end else begin
        dp_ready_in = (mode == 0) ? 1'b1 : 1'($urandom);
      end
      tick();
      n++;
    end
    if (cap) verifica("rem_timeout", (n < 200), 1);
    aa_pronto_in = 1'b1;
    for (int k = 0; k < esp; k++) begin
      verifica("espera_busy", dp_ocupado_out, cap);
      tick();
    end
    aa_pronto_in = 1'b0;
    aa_tem_aprovado_in = 1'b0;
    dp_ready_in = 1'b0;
    tick();
    verifica("idle", dp_ocupado_out, 0);
    tick();
    verifica("n_wr", wr_q.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wr_q.size(); i++)
      verifica("wr", wr_q[i], ew[i]);
    verifica("n_dp", dp_q.size(), ed.size());
    for (int i = 0; i < ed.size() && i < dp_q.size(); i++)
      verifica("dp", dp_q[i], ed[i]);
    verifica("rem", rem_cnt - rem0, cap ? 1 : 0);
    verifica("flag", dp_destino_encontrado_out, flag_m);
  endtask

  task automatic limpa();
    limpar_in = 1'b1;
    tick();
    limpar_in = 1'b0;
    flag_m = 0;
    verifica("clr_flag", dp_destino_encontrado_out, 0);
    verifica("clr_busy", dp_ocupado_out, 0);
  endtask

  initial begin
    int n;
    int rem0;
    logic [19:0] ad;
    logic [4:0]  de;
    rst_n = 1'b0;
    aa_pronto_in = 0;
    aa_tem_aprovado_in = 0;
    aa_aprovado_in = 0;
    aa_endereco_in = 0;
    aa_distancia_in = 0;
    aa_anterior_data_in = 0;
    destino_in = 0;
    limpar_in = 0;
    dp_ready_in = 0;
    #12;
    verifica("rst_outs",
      {dp_valid_out, dp_endereco_out, dp_distancia_out, ant_wr_en_out,
       ant_wr_addr_out, ant_wr_data_out, remover_aprovados_out,
       dp_destino_encontrado_out, dp_ocupado_out}, 0);
    rst_n = 1'b1;
    tick();

    // Two approved slots, ready high, latency check
    run_txn(4'b0101, {5'd3, 5'd9, 5'd5, 5'd2},
            {5'd4, 5'd8, 5'd12, 5'd16},
            {5'd0, 5'd1, 5'd0, 5'd7}, 5'd31, 0, 0, 0);
    verifica("lat_wr0", wr_cyc_q.size() > 0 ? wr_cyc_q[0] : -1, c0 + 2);
    verifica("lat_v0", vcyc_q.size() > 0 ? vcyc_q[0] : -1, c0 + 3);
    verifica("lat_wr1", wr_cyc_q.size() > 1 ? wr_cyc_q[1] : -1, c0 + 5);

    // Same with backpressure at first offer
    run_txn(4'b0101, {5'd3, 5'd9, 5'd5, 5'd2},
            {5'd4, 5'd8, 5'd12, 5'd16},
            {5'd0, 5'd1, 5'd0, 5'd7}, 5'd31, 0, 5, 0);

    // Target in slot 0, then capture ignored until clear
    run_txn(4'b0011, {5'd3, 5'd9, 5'd5, 5'd31},
            {5'd1, 5'd2, 5'd3, 5'd4},
            {5'd6, 5'd6, 5'd6, 5'd2}, 5'd31, 0, 0, 0);
    run_txn(4'b0001, {5'd3, 5'd9, 5'd5, 5'd4},
            {5'd1, 5'd2, 5'd3, 5'd4},
            {5'd6, 5'd6, 5'd6, 5'd2}, 5'd31, 0, 0, 0);
    limpa();

    // Single top slot, ESPERA hold of 3 cycles
    run_txn(4'b1000, {5'd17, 5'd9, 5'd5, 5'd4},
            {5'd30, 5'd2, 5'd3, 5'd4},
            {5'd11, 5'd6, 5'd6, 5'd2}, 5'd0, 0, 0, 3);

    // Clear during ENVIA
    destino_in = 5'd31;
    aa_aprovado_in = 4'b0010;
    aa_endereco_in = {5'd1, 5'd2, 5'd3, 5'd4};
    aa_pronto_in = 1;
    aa_tem_aprovado_in = 1;
    dp_ready_in = 0;
    tick();
    aa_pronto_in = 0;
    n = 0;
    while (!dp_valid_out && n < 20) begin
      tick();
      n++;
    end
    verifica("envia_reach", dp_valid_out, 1);
    rem0 = rem_cnt;
    limpar_in = 1;
    tick();
    limpar_in = 0;
    aa_tem_aprovado_in = 0;
    verifica("clr_valid", dp_valid_out, 0);
    verifica("clr_ocup", dp_ocupado_out, 0);
    repeat (3) tick();
    verifica("clr_norem", rem_cnt - rem0, 0);

    // Reset during ESCREVE
    aa_aprovado_in = 4'b0001;
    aa_pronto_in = 1;
    aa_tem_aprovado_in = 1;
    tick();
    aa_pronto_in = 0;
    n = 0;
    while (!ant_wr_en_out && n < 20) begin
      tick();
      n++;
    end
    verifica("escreve_reach", ant_wr_en_out, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    verifica("rst_async",
      {dp_valid_out, dp_endereco_out, dp_distancia_out, ant_wr_en_out,
       ant_wr_addr_out, ant_wr_data_out, remover_aprovados_out,
       dp_destino_encontrado_out, dp_ocupado_out}, 0);
    aa_pronto_in = 1;
    aa_tem_aprovado_in = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (3) begin
      tick();
      verifica("rst_idle", dp_ocupado_out, 0);
    end
    aa_pronto_in = 0;
    flag_m = 0;

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      ad = 20'($urandom);
      de = ($urandom_range(0, 2) == 0) ? ad[5*$urandom_range(0, 3) +: 5]
                                       : 5'($urandom);
      run_txn(4'($urandom), ad, 20'($urandom), 20'($urandom), de,
              1, $urandom_range(0, 2), $urandom_range(0, 3));
      if (flag_m && $urandom_range(0, 1) == 1) limpa();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
